iob_vexriscv_dbus_bridge: RTL

Parametrised data-bus bridge between the VexRiscv simple dBus (cmd/rsp) and the IOb native memory bus. It replaces the combinational tie-off, where cmd_ready equals cmd_valid and write data is unshifted, with a registered single-outstanding transaction engine. The engine adds byte-lane steering and strobe generation for 32- or 64-bit data paths, misaligned-access rejection, and a bus timeout that returns an error response. It sits between the core's dBus ports and the interconnect data port inside the CPU wrapper.

---
 rtl/iob_vexriscv_dbus_bridge.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/iob_vexriscv_dbus_bridge.sv
// iob_vexriscv_dbus_bridge: registered single-outstanding bridge from VexRiscv simple dBus to IOb native bus
// with lane steering, strobe generation, misalignment rejection and bus timeout.
module iob_vexriscv_dbus_bridge #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int TIMEOUT_W = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic                cmd_wr,
   input  logic [ADDR_W-1:0]   cmd_address,
   input  logic [DATA_W-1:0]   cmd_data,
   input  logic [1:0]          cmd_size,
   output logic                rsp_ready,
   output logic                rsp_error,
   output logic [DATA_W-1:0]   rsp_data,
   output logic                mem_valid,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_wstrb,
   input  logic [DATA_W-1:0]   mem_rdata,
   input  logic                mem_ready,
   output logic                busy,
   output logic                err_misalign,
   output logic                err_timeout
);
   localparam int NB = DATA_W / 8;
   localparam int OFF = $clog2(NB);
   localparam logic [1:0] OFF_SZ = 2'(OFF);
   localparam logic [TIMEOUT_W-1:0] CNT_LAST = {TIMEOUT_W{1'b1}} - TIMEOUT_W'(1);

   typedef enum logic [1:0] {IDLE, REQ, ERR} state_t;

   state_t                state_q, state_d;
   logic [TIMEOUT_W-1:0]  cnt_q, cnt_d;
   logic                  wr_q, wr_d;
   logic                  mem_valid_q, mem_valid_d;
   logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;
   logic [NB-1:0]         mem_wstrb_q, mem_wstrb_d;
   logic                  rsp_ready_q, rsp_ready_d;
   logic                  rsp_error_q, rsp_error_d;
   logic [DATA_W-1:0]     rsp_data_q, rsp_data_d;
   logic                  err_mis_q, err_mis_d;
   logic                  err_to_q, err_to_d;
   logic                  busy_q;

   logic [OFF-1:0]        lane, amask;
   logic                  legal;
   logic [NB-1:0]         strb_base;
   logic [DATA_W-1:0]     wdata_rep;

   assign lane = cmd_address[OFF-1:0];
   assign amask = cmd_size == 2'd0 ? '0 : cmd_size == 2'd1 ? OFF'(1) : cmd_size == 2'd2 ? OFF'(3) : OFF'(7);
   assign legal = (cmd_size <= OFF_SZ) && ((lane & amask) == '0);
   assign strb_base = cmd_size == 2'd0 ? NB'(1) : cmd_size == 2'd1 ? NB'(3) : cmd_size == 2'd2 ? NB'(15) : NB'(255);
   assign wdata_rep = cmd_size == 2'd0 ? {NB{cmd_data[7:0]}} :
                      cmd_size == 2'd1 ? {(NB/2){cmd_data[15:0]}} :
                      cmd_size == 2'd2 ? {(NB/4){cmd_data[31:0]}} : cmd_data;

   // A timed-out load answers one cycle after err_timeout; wr_q still describes that request then.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      wr_d        = wr_q;
      mem_valid_d = mem_valid_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_wstrb_d = mem_wstrb_q;
      rsp_ready_d = err_to_q & ~wr_q;
      rsp_error_d = err_to_q & ~wr_q;
      rsp_data_d  = rsp_data_q;
      err_mis_d   = 1'b0;
      err_to_d    = 1'b0;
      case (state_q)
         IDLE: if (cmd_valid) begin
            wr_d = cmd_wr;
            if (legal) begin
               mem_addr_d  = {cmd_address[ADDR_W-1:OFF], {OFF{1'b0}}};
               mem_wstrb_d = cmd_wr ? strb_base << lane : '0;
               mem_wdata_d = wdata_rep;
               mem_valid_d = 1'b1;
               cnt_d       = '0;
               state_d     = REQ;
            end else begin
               err_mis_d   = 1'b1;
               rsp_ready_d = rsp_ready_d | ~cmd_wr;
               rsp_error_d = rsp_error_d | ~cmd_wr;
               rsp_data_d  = '0;
               state_d     = ERR;
            end
         end
         REQ: if (mem_ready) begin
            rsp_data_d  = mem_rdata;
            rsp_ready_d = ~wr_q;
            mem_valid_d = 1'b0;
            state_d     = IDLE;
         end else if (cnt_q == CNT_LAST) begin
            cnt_d       = cnt_q + TIMEOUT_W'(1);
            rsp_data_d  = '0;
            err_to_d    = 1'b1;
            mem_valid_d = 1'b0;
            state_d     = IDLE;
         end else begin
            cnt_d = cnt_q + TIMEOUT_W'(1);
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         wr_q        <= 1'b0;
         mem_valid_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_wstrb_q <= '0;
         rsp_ready_q <= 1'b0;
         rsp_error_q <= 1'b0;
         rsp_data_q  <= '0;
         err_mis_q   <= 1'b0;
         err_to_q    <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         wr_q        <= wr_d;
         mem_valid_q <= mem_valid_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_wstrb_q <= mem_wstrb_d;
         rsp_ready_q <= rsp_ready_d;
         rsp_error_q <= rsp_error_d;
         rsp_data_q  <= rsp_data_d;
         err_mis_q   <= err_mis_d;
         err_to_q    <= err_to_d;
         busy_q      <= state_d != IDLE;
      end
   end

   assign cmd_ready    = state_q == IDLE;
   assign rsp_ready    = rsp_ready_q;
   assign rsp_error    = rsp_error_q;
   assign rsp_data     = rsp_data_q;
   assign mem_valid    = mem_valid_q;
   assign mem_addr     = mem_addr_q;
   assign mem_wdata    = mem_wdata_q;
   assign mem_wstrb    = mem_wstrb_q;
   assign busy         = busy_q;
   assign err_misalign = err_mis_q;
   assign err_timeout  = err_to_q;
endmodule
